// File: rtl/fir_serial_mac_pkg.sv
// Shared definitions for the time-multiplexed FIR MAC controller:
// FSM encoding, width derivations and a sign-extension helper.
package fir_serial_mac_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_NUM_TAPS   = 8;

  // Widest value the sign-extension helper can handle.
  localparam int SEXT_MAX_W = 64;

  // FSM encoding; kept as plain constants so older tools can read them.
  localparam int         STATE_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of the tap counter / coefficient address.
  function automatic int tap_cnt_width_f(input int num_taps);
    return $clog2(num_taps);
  endfunction

  // Accumulator width: full product plus log2(taps) guard bits.
  function automatic int acc_width_f(input int data_w, input int num_taps);
    return (2 * data_w) + $clog2(num_taps);
  endfunction

  // Treat the low src_w bits of value as signed and extend to SEXT_MAX_W.
  function automatic logic signed [SEXT_MAX_W-1:0] sext_f(
    input logic [SEXT_MAX_W-1:0] value,
    input int                    src_w
  );
    logic signed [SEXT_MAX_W-1:0] v_s;
    v_s = $signed(value << (SEXT_MAX_W - src_w));
    return v_s >>> (SEXT_MAX_W - src_w);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// FIR sample delay line: x[0] is the newest sample, the line shifts by one
// position on every accepted sample, and any tap can be read by index.
module fir_delay_line
  import fir_serial_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_NUM_TAPS
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_shift,
  input  logic signed [DATA_WIDTH-1:0]   i_din,
  input  logic        [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic signed [DATA_WIDTH-1:0]   o_rd_data
);

  logic signed [DATA_WIDTH-1:0] r_tap [DEPTH];

  // Shift a new sample in at x[0]; everything cleared on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tap[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (i_shift) begin
      r_tap[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_tap[i] <= r_tap[i-1];
      end
    end
  end

  assign o_rd_data = r_tap[i_rd_idx];

endmodule

// File: rtl/fir_serial_mac.sv
// Serial FIR controller: walks the taps one per cycle, drives the external
// signed multiplier with registered operands and accumulates its product.
module fir_serial_mac
  import fir_serial_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int ACC_WIDTH  = acc_width_f(DATA_WIDTH, NUM_TAPS)
) (
  input  logic                            CLK_100MHz,
  input  logic                            nRST,
  input  logic signed [DATA_WIDTH-1:0]    DIN,
  input  logic                            DIN_VALID,
  output logic                            DIN_READY,
  input  logic                            COEFF_WE,
  input  logic        [$clog2(NUM_TAPS)-1:0] COEFF_ADDR,
  input  logic signed [DATA_WIDTH-1:0]    COEFF_DATA,
  output logic signed [DATA_WIDTH-1:0]    MULT_A,
  output logic signed [DATA_WIDTH-1:0]    MULT_B,
  input  logic signed [2*DATA_WIDTH-1:0]  MULT_Q,
  output logic signed [ACC_WIDTH-1:0]     DOUT,
  output logic                            DOUT_VALID
);

  localparam int               TAP_W  = tap_cnt_width_f(NUM_TAPS);
  localparam logic [TAP_W-1:0] K_LAST = TAP_W'(NUM_TAPS - 1);
  localparam int               PROD_W = 2 * DATA_WIDTH;

  // Registered state and outputs
  logic [STATE_W-1:0]           r_state;
  logic [TAP_W-1:0]             r_k;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [DATA_WIDTH-1:0] r_coeff [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] r_mult_a;
  logic signed [DATA_WIDTH-1:0] r_mult_b;
  logic signed [ACC_WIDTH-1:0]  r_dout;
  logic                         r_dout_valid;
  logic                         r_din_ready;

  // Combinational helpers
  logic [STATE_W-1:0]           w_state_nxt;
  logic                         w_accept;
  logic                         w_coeff_wr;
  logic                         w_last_tap;
  logic [TAP_W-1:0]             w_k_nxt;
  logic signed [DATA_WIDTH-1:0] w_dl_rd;
  logic signed [DATA_WIDTH-1:0] w_coeff0_eff;
  logic signed [DATA_WIDTH-1:0] w_mult_a_nxt;
  logic signed [DATA_WIDTH-1:0] w_mult_b_nxt;
  logic signed [ACC_WIDTH-1:0]  w_q_ext;

  // A sample is only taken while idle and advertising ready, which also
  // keeps the very first cycle after reset release from accepting.
  assign w_accept   = (r_state == ST_IDLE) && r_din_ready && DIN_VALID;
  // Coefficients are frozen for the whole computation.
  assign w_coeff_wr = (r_state == ST_IDLE) && COEFF_WE;
  assign w_last_tap = (r_k == K_LAST);
  assign w_k_nxt    = r_k + {{(TAP_W-1){1'b0}}, 1'b1};

  // A same-cycle write to c[0] must already be seen by the first tap.
  assign w_coeff0_eff = (w_coeff_wr && (COEFF_ADDR == {TAP_W{1'b0}}))
                        ? COEFF_DATA : r_coeff[0];

  assign w_q_ext = ACC_WIDTH'(sext_f({{(SEXT_MAX_W-PROD_W){1'b0}}, MULT_Q}, PROD_W));

  // Delay line is read one tap ahead so the operand register is ready
  // exactly when the counter reaches that tap.
  fir_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_TAPS)
  ) u_delay_line (
    .i_clk     (CLK_100MHz),
    .i_rst_n   (nRST),
    .i_shift   (w_accept),
    .i_din     (DIN),
    .i_rd_idx  (w_k_nxt),
    .o_rd_data (w_dl_rd)
  );

  // Next-state decode for the IDLE -> MAC -> DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_MAC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (w_last_tap) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_MAC;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand selection for the next cycle; zero whenever no tap is in flight.
  always_comb begin
    w_mult_a_nxt = {DATA_WIDTH{1'b0}};
    w_mult_b_nxt = {DATA_WIDTH{1'b0}};
    if (w_accept) begin
      w_mult_a_nxt = DIN;
      w_mult_b_nxt = w_coeff0_eff;
    end else if ((r_state == ST_MAC) && !w_last_tap) begin
      w_mult_a_nxt = w_dl_rd;
      w_mult_b_nxt = r_coeff[w_k_nxt];
    end else begin
      w_mult_a_nxt = {DATA_WIDTH{1'b0}};
      w_mult_b_nxt = {DATA_WIDTH{1'b0}};
    end
  end

  // Coefficient register file, writable only while idle.
  always_ff @(posedge CLK_100MHz or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_coeff[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_coeff_wr) begin
      r_coeff[COEFF_ADDR] <= COEFF_DATA;
    end
  end

  // FSM state, tap counter and ready flag.
  always_ff @(posedge CLK_100MHz or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_k         <= {TAP_W{1'b0}};
      r_din_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_din_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_k <= {TAP_W{1'b0}};
      end else if (r_state == ST_MAC) begin
        r_k <= w_k_nxt;
      end
    end
  end

  // Accumulate the multiplier product of the operands presented this cycle.
  always_ff @(posedge CLK_100MHz or negedge nRST) begin
    if (!nRST) begin
      r_acc <= {ACC_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_acc <= {ACC_WIDTH{1'b0}};
    end else if (r_state == ST_MAC) begin
      r_acc <= r_acc + w_q_ext;
    end
  end

  // Registered multiplier operands.
  always_ff @(posedge CLK_100MHz or negedge nRST) begin
    if (!nRST) begin
      r_mult_a <= {DATA_WIDTH{1'b0}};
      r_mult_b <= {DATA_WIDTH{1'b0}};
    end else begin
      r_mult_a <= w_mult_a_nxt;
      r_mult_b <= w_mult_b_nxt;
    end
  end

  // Result register: loaded in DONE and held until the next result.
  always_ff @(posedge CLK_100MHz or negedge nRST) begin
    if (!nRST) begin
      r_dout       <= {ACC_WIDTH{1'b0}};
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_dout <= r_acc;
      end
    end
  end

  assign DIN_READY  = r_din_ready;
  assign MULT_A     = r_mult_a;
  assign MULT_B     = r_mult_b;
  assign DOUT       = r_dout;
  assign DOUT_VALID = r_dout_valid;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Self-checking bench for fir_serial_mac with a behavioural signed multiplier
// and a scoreboard of expected filter outputs and their due cycles.
module tb_fir_serial_mac;

  localparam int DW = 6;
  localparam int NT = 8;
  localparam int KW = 3;
  localparam int AW = 2 * DW + KW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic signed [DW-1:0]  din = '0;
  logic                  din_valid = 1'b0;
  logic                  din_ready;
  logic                  coeff_we = 1'b0;
  logic [KW-1:0]         coeff_addr = '0;
  logic signed [DW-1:0]  coeff_data = '0;
  logic signed [DW-1:0]  mult_a;
  logic signed [DW-1:0]  mult_b;
  logic signed [2*DW-1:0] mult_q;
  logic signed [AW-1:0]  dout;
  logic                  dout_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_dout = 0;
  int m_x [NT];
  int m_c [NT];

  typedef struct {
    int val;
    int due;
  } exp_t;
  exp_t sb_q[$];

  fir_serial_mac #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
    .CLK_100MHz (clk),
    .nRST       (rst_n),
    .DIN        (din),
    .DIN_VALID  (din_valid),
    .DIN_READY  (din_ready),
    .COEFF_WE   (coeff_we),
    .COEFF_ADDR (coeff_addr),
    .COEFF_DATA (coeff_data),
    .MULT_A     (mult_a),
    .MULT_B     (mult_b),
    .MULT_Q     (mult_q),
    .DOUT       (dout),
    .DOUT_VALID (dout_valid)
  );

  // Combinational signed multiplier standing in for MULT_LUT_SIGNED.
  assign mult_q = mult_a * mult_b;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every DOUT_VALID pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (dout_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_dout_valid: DOUT=%0d at cycle %0d, no sample pending", dout, cyc);
      end else begin
        e = sb_q.pop_front();
        n_vec++;
        if (dout !== AW'(e.val)) begin
          n_err++;
          $display("FAIL dout_value: got %0d, expected %0d", dout, e.val);
        end
        n_vec++;
        if (cyc !== e.due) begin
          n_err++;
          $display("FAIL dout_latency: valid at cycle %0d, expected cycle %0d", cyc, e.due);
        end
        last_dout = dout;
      end
    end
  end

  // Model of the filter: shift, then sum c[k]*x[k]; result due 10 cycles on.
  task automatic model_accept(input int v);
    int s;
    for (int k = NT - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = v;
    s = 0;
    for (int k = 0; k < NT; k++) s += m_c[k] * m_x[k];
    sb_q.push_back('{s, cyc + NT + 2});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    for (int k = 0; k < NT; k++) begin m_x[k] = 0; m_c[k] = 0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (din_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: DIN_READY stayed %b for 50 cycles, expected 1", din_ready);
    end
  endtask

  task automatic write_coeff(input int addr, input int val);
    bit ok;
    wait_ready(ok);
    coeff_we = 1'b1; coeff_addr = KW'(addr); coeff_data = DW'(val);
    m_c[addr] = val;
    @(posedge clk); #1;
    coeff_we = 1'b0;
  endtask

  task automatic send_sample(input int v, input bit we, input int addr, input int val);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      din = DW'(v); din_valid = 1'b1;
      coeff_we = we; coeff_addr = KW'(addr); coeff_data = DW'(val);
      if (we) m_c[addr] = val;
      model_accept(v);
      @(posedge clk); #1;
      din_valid = 1'b0; coeff_we = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
    end
  endtask

  task automatic check_last(input string tag, input int exp);
    n_vec++;
    if (last_dout !== exp) begin
      n_err++;
      $display("FAIL %s: last DOUT %0d, expected %0d", tag, last_dout, exp);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({dout, dout_valid, mult_a, mult_b} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: DOUT=%0d VALID=%b A=%0d B=%0d, expected all 0", dout, dout_valid, mult_a, mult_b);
    end
    do_reset();
    @(negedge clk);
    n_vec++;
    if (din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_ready: DIN_READY=%b, expected 1", din_ready);
    end
    n_vec++;
    if ({dout, dout_valid, mult_a, mult_b} !== '0) begin
      n_err++;
      $display("FAIL idle_outputs: DOUT=%0d VALID=%b A=%0d B=%0d, expected all 0", dout, dout_valid, mult_a, mult_b);
    end
  endtask

  task automatic test_ones();
    do_reset();
    for (int k = 0; k < NT; k++) write_coeff(k, 1);
    for (int i = 0; i < NT + 1; i++) send_sample(1, 1'b0, 0, 0);
    drain();
    check_last("ones_steady", 8);
    n_vec++;
    if ({mult_a, mult_b} !== '0) begin
      n_err++;
      $display("FAIL idle_operands: A=%0d B=%0d, expected 0", mult_a, mult_b);
    end
  endtask

  task automatic test_impulse();
    do_reset();
    for (int k = 0; k < NT; k++) write_coeff(k, k + 1);
    send_sample(1, 1'b0, 0, 0);
    for (int i = 0; i < NT - 1; i++) send_sample(0, 1'b0, 0, 0);
    drain();
    check_last("impulse_pos", 8);
    do_reset();
    for (int k = 0; k < NT; k++) write_coeff(k, k + 1);
    send_sample(-1, 1'b0, 0, 0);
    for (int i = 0; i < NT - 1; i++) send_sample(0, 1'b0, 0, 0);
    drain();
    check_last("impulse_neg", -8);
  endtask

  task automatic test_extremes();
    do_reset();
    for (int k = 0; k < NT; k++) write_coeff(k, -32);
    for (int i = 0; i < NT; i++) send_sample(-32, 1'b0, 0, 0);
    drain();
    check_last("extreme_max", 8192);
    do_reset();
    for (int k = 0; k < NT; k++) write_coeff(k, -32);
    for (int i = 0; i < NT; i++) send_sample(31, 1'b0, 0, 0);
    drain();
    check_last("extreme_mixed", -7936);
  endtask

  task automatic test_back_to_back();
    int n_acc;
    int prev;
    bit just;
    do_reset();
    for (int k = 0; k < NT; k++) write_coeff(k, k + 1);
    din = DW'($urandom_range(1, 31));
    din_valid = 1'b1;
    n_acc = 0; prev = -1; just = 1'b0;
    for (int i = 0; i < 80 && n_acc < 4; i++) begin
      @(negedge clk);
      coeff_we = 1'b0;
      if (just) begin
        din = DW'($urandom_range(1, 31));
        coeff_we = 1'b1; coeff_addr = '0; coeff_data = 6'sd17;
        just = 1'b0;
      end
      if (din_ready === 1'b1) begin
        model_accept(din);
        if (prev >= 0) begin
          n_vec++;
          if (cyc - prev !== NT + 2) begin
            n_err++;
            $display("FAIL accept_interval: %0d cycles, expected %0d", cyc - prev, NT + 2);
          end
        end
        prev = cyc; n_acc++; just = 1'b1;
      end
    end
    @(posedge clk); #1;
    din_valid = 1'b0; coeff_we = 1'b0;
    n_vec++;
    if (n_acc !== 4) begin
      n_err++;
      $display("FAIL accept_count: %0d acceptances, expected 4", n_acc);
    end
    drain();
  endtask

  task automatic test_abort();
    int n_valid;
    do_reset();
    for (int k = 0; k < NT; k++) write_coeff(k, 1);
    send_sample(7, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    for (int k = 0; k < NT; k++) begin m_x[k] = 0; m_c[k] = 0; end
    #1;
    n_vec++;
    if ({dout, dout_valid, mult_a, mult_b} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: DOUT=%0d VALID=%b A=%0d B=%0d, expected all 0", dout, dout_valid, mult_a, mult_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dout_valid === 1'b1) n_valid++;
    end
    n_vec++;
    if (n_valid !== 0) begin
      n_err++;
      $display("FAIL abort_no_valid: %0d DOUT_VALID pulses, expected 0", n_valid);
    end
    n_vec++;
    if (dout !== '0) begin
      n_err++;
      $display("FAIL abort_dout: DOUT=%0d, expected 0", dout);
    end
    for (int k = 0; k < NT; k++) write_coeff(k, 1);
    send_sample(5, 1'b1, 0, 2);
    drain();
    check_last("after_abort", 10);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_impulse();
    test_extremes();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
- Time-multiplexed FIR filter controller that drives the operand ports of the combinational signed LUT multiplier (MULT_LUT_SIGNED).
- Accumulates the multiplier's product output over NUM_TAPS cycles and emits one filtered sample per accepted input sample.
- Sits on both sides of the multiplier: upstream it feeds operands A/B, downstream it consumes Q.

Parameters:
DATA_WIDTH, 6, signed width of samples, coefficients and multiplier operands
NUM_TAPS, 8, number of FIR taps; power of two, at least 2
ACC_WIDTH, 2*DATA_WIDTH+$clog2(NUM_TAPS), signed accumulator/output width

Ports:
CLK_100MHz  in  1  system clock, rising edge
nRST  in  1  reset; asynchronous, active-low
DIN  in  DATA_WIDTH  signed input sample
DIN_VALID  in  1  DIN is valid
DIN_READY  out  1  block can accept a sample
COEFF_WE  in  1  coefficient write strobe
COEFF_ADDR  in  $clog2(NUM_TAPS)  coefficient index k
COEFF_DATA  in  DATA_WIDTH  signed coefficient c[k]
MULT_A  out  DATA_WIDTH  multiplier operand A (delay-line sample)
MULT_B  out  DATA_WIDTH  multiplier operand B (coefficient)
MULT_Q  in  2*DATA_WIDTH  signed product A*B from the multiplier, combinational in the same cycle
DOUT  out  ACC_WIDTH  signed filter result y
DOUT_VALID  out  1  one-cycle pulse, DOUT is new

Behaviour:
- Function: y = sum over k=0..NUM_TAPS-1 of c[k]*x[k]. x[0] is the newest sample; delay line shifts by one on each accepted sample.
- Reset (nRST=0, asynchronous):
  - state=IDLE; delay line, coefficients, accumulator and tap counter cleared to 0.
  - DOUT=0, DOUT_VALID=0, MULT_A=0, MULT_B=0.
  - DIN_READY=1 from the first clock edge after nRST deasserts.
- FSM states:
  - IDLE: DIN_READY=1. DIN_VALID=1 shifts DIN into x[0], clears the accumulator and tap counter, and moves to MAC.
  - MAC: DIN_READY=0. Tap counter k runs 0..NUM_TAPS-1, one tap per cycle; MULT_A=x[k], MULT_B=c[k].
    - Each cycle, acc <= acc + sign_extend(MULT_Q).
    - After k=NUM_TAPS-1 is accumulated, move to DONE.
  - DONE: DOUT <= final acc; DOUT_VALID=1 for exactly this cycle. Then move to IDLE.
- Latency: sample accepted at edge t → MAC edges t+1..t+NUM_TAPS → DOUT_VALID high in the cycle after edge t+NUM_TAPS+1. Throughput is one sample per NUM_TAPS+2 cycles.
- MULT_A and MULT_B are registered outputs, so operands are stable for a full cycle. MULT_Q is sampled on the edge ending that cycle.
- Operands are 0 outside MAC, so the multiplier output is 0 when idle.
- DOUT holds its value until the next DONE.
- Arithmetic: MULT_Q is sign-extended to ACC_WIDTH. The accumulator cannot overflow at defaults: worst case 8*(-32*-32)=8192 against a 15-bit signed range. Overflow is not checked.
- COEFF_WE is honoured only in IDLE. Writes in MAC/DONE are dropped, so coefficients are stable during a computation.
- In IDLE, a coefficient write and a sample acceptance in the same cycle: the write takes effect first and is used by that computation.
- DIN_VALID held high while DIN_READY=0: no sample is taken. DIN is accepted on the first IDLE cycle.
- nRST low mid-MAC: computation aborted, no DOUT_VALID, all state cleared as at reset.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, MAC, DONE).
  - Localparams for the ACC_WIDTH derivation and the tap-counter width.
  - Sign-extension helper function.
- One natural sub-module: fir_delay_line (shift register with a read mux by k). Coefficient storage stays inline as a register array.
- The multiplier is instantiated next to this block at the level above, not inside it.

Test Plan:
- Reset then idle: DIN_READY=1, DOUT=0, DOUT_VALID=0, MULT_A=MULT_B=0.
- All c[k]=1; feed DIN=1 eight times → DOUT sequence 1,2,3,4,5,6,7,8. A ninth sample of 1 → 8. DOUT_VALID appears NUM_TAPS+1 cycles after each acceptance.
- Impulse: c[k]=k+1 (1..8); DIN=1 then seven 0s → DOUT 1,2,3,4,5,6,7,8. Negative impulse DIN=-1 with c=1..8 → -1..-8.
- Extremes: all c[k]=-32, eight samples of -32 → final DOUT=8192. Mixed case c=-32, x=31 → -7936.
- Back-pressure and write masking: hold DIN_VALID=1 continuously → exactly one acceptance per 10 cycles. COEFF_WE to address 0 during MAC → ignored, c[0] unchanged.
- Pull nRST low during MAC tap 3 → no DOUT_VALID. After release, DOUT=0 and the delay line reads 0; next computation with DIN=5 and c[0]=2 gives 10.
